// File: rtl/avalon_edge_input_pio.sv
// Avalon-MM input PIO: synchronised, debounced inputs with edge capture
// and a maskable level interrupt. Zero-wait-state, read-latency-0 slave.
module avalon_edge_input_pio #(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] INPUT_RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] samp;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] clr;
    logic             wr_en;

    // Bits of writedata above WIDTH have no destination.
    logic unused_writedata;
    assign unused_writedata = &{1'b0, writedata};

    assign tick  = (cnt == CNT_MAX);
    assign wr_en = chipselect & ~write_n;
    assign clr   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // Free-running debounce tick counter, independent of bus activity.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Two-flop synchroniser for the asynchronous inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= INPUT_RESET_VAL;
            sync2 <= INPUT_RESET_VAL;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a level only when two consecutive ticks agree.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            samp <= INPUT_RESET_VAL;
            deb  <= INPUT_RESET_VAL;
        end else if (tick) begin
            samp <= sync2;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (samp[i] == sync2[i]) begin
                    deb[i] <= sync2[i];
                end
            end
        end
    end

    // Delayed copy of the debounced value for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_d <= INPUT_RESET_VAL;
        end else begin
            deb_d <= deb;
        end
    end

    // Select which debounced transitions qualify for capture.
    always_comb begin
        edge_hit = '0;
        case (EDGE_TYPE)
            1:       edge_hit = ~deb & deb_d;
            2:       edge_hit = deb ^ deb_d;
            default: edge_hit = deb & ~deb_d;
        endcase
    end

    // Interrupt mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask <= '0;
        end else if (wr_en && address == 2'd1) begin
            mask <= writedata[WIDTH-1:0];
        end
    end

    // Edge capture with write-1-to-clear; a coincident edge beats the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap <= '0;
        end else begin
            cap <= (cap & ~clr) | edge_hit;
        end
    end

    // Combinational read mux; unused upper bits read as zero.
    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = deb;
            2'd1:    readdata[WIDTH-1:0] = mask;
            2'd3:    readdata[WIDTH-1:0] = cap;
            default: readdata = '0;
        endcase
    end

    assign irq = |(cap & mask);

endmodule

// File: tb/tb_avalon_edge_input_pio.sv
// Bench for avalon_edge_input_pio: two instances (rising/reset 0x00 and
// falling/reset 0xFF), a history-based reference model checked every cycle,
// plus directed literal checks.
module tb_avalon_edge_input_pio;

    localparam int D = 4;

    logic        clk;
    logic        rst_n;
    logic [1:0]  addr  [2];
    logic        cs    [2];
    logic        wn    [2];
    logic [31:0] wd    [2];
    logic [7:0]  inp   [2];
    logic [31:0] rd    [2];
    logic        irq_o [2];

    int n_vec;
    int n_err;

    avalon_edge_input_pio #(
        .WIDTH(8), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0), .INPUT_RESET_VAL(8'h00)
    ) dut0 (
        .clk(clk), .reset_n(rst_n), .address(addr[0]), .chipselect(cs[0]),
        .write_n(wn[0]), .writedata(wd[0]), .in_port(inp[0]),
        .readdata(rd[0]), .irq(irq_o[0])
    );

    avalon_edge_input_pio #(
        .WIDTH(8), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1), .INPUT_RESET_VAL(8'hFF)
    ) dut1 (
        .clk(clk), .reset_n(rst_n), .address(addr[1]), .chipselect(cs[1]),
        .write_n(wn[1]), .writedata(wd[1]), .in_port(inp[1]),
        .readdata(rd[1]), .irq(irq_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // hist[i][k] = in_port value seen just before edge (e-1-k).
    logic [7:0] hist   [2][8];
    logic [7:0] m_deb  [2];
    logic [7:0] m_old  [2];
    logic [7:0] m_cap  [2];
    logic [7:0] m_mask [2];
    int         m_e;

    function automatic logic [7:0] rst_val(input int i);
        return (i == 0) ? 8'h00 : 8'hFF;
    endfunction

    function automatic logic [7:0] qual(input int i, input logic [7:0] nw, input logic [7:0] od);
        return (i == 0) ? (nw & ~od) : (~nw & od);
    endfunction

    function automatic logic [31:0] exp_rd(input int i, input logic [1:0] a);
        case (a)
            2'd0:    return {24'h0, m_deb[i]};
            2'd1:    return {24'h0, m_mask[i]};
            2'd3:    return {24'h0, m_cap[i]};
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        m_e = 0;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 8; k++) hist[i][k] = rst_val(i);
            m_deb[i] = rst_val(i); m_old[i] = rst_val(i);
            m_cap[i] = 8'h00; m_mask[i] = 8'h00;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_e = 0;
                for (int i = 0; i < 2; i++) begin
                    for (int k = 0; k < 8; k++) hist[i][k] = rst_val(i);
                    m_deb[i] = rst_val(i); m_old[i] = rst_val(i);
                    m_cap[i] = 8'h00; m_mask[i] = 8'h00;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    logic [7:0] clrm;
                    logic [7:0] nd;
                    clrm = (cs[i] && !wn[i] && addr[i] == 2'd3) ? wd[i][7:0] : 8'h00;
                    m_cap[i] = (m_cap[i] & ~clrm) | qual(i, m_deb[i], m_old[i]);
                    if (cs[i] && !wn[i] && addr[i] == 2'd1) m_mask[i] = wd[i][7:0];
                    // A level is accepted on a tick edge if the delayed input
                    // equals the delayed input one debounce period earlier.
                    nd = m_deb[i];
                    if ((m_e % D) == D - 1) begin
                        for (int b = 0; b < 8; b++)
                            if (hist[i][1][b] == hist[i][1 + D][b]) nd[b] = hist[i][1][b];
                    end
                    m_old[i] = m_deb[i];
                    m_deb[i] = nd;
                    for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k - 1];
                    hist[i][0] = inp[i];
                end
                m_e++;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                check($sformatf("cyc_rd%0d_a%0d", i, addr[i]), rd[i], exp_rd(i, addr[i]));
                check($sformatf("cyc_irq%0d", i), {31'h0, irq_o[i]}, {31'h0, |(m_cap[i] & m_mask[i])});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int i, input logic [1:0] a, input logic [31:0] d);
        cs[i] = 1'b1; wn[i] = 1'b0; addr[i] = a; wd[i] = d;
        @(negedge clk);
        cs[i] = 1'b0; wn[i] = 1'b1; wd[i] = 32'h0;
    endtask

    task automatic rd_chk(input int i, input logic [1:0] a, input logic [31:0] exp, input string name);
        addr[i] = a;
        #1;
        check(name, rd[i], exp);
    endtask

    task automatic irq_chk(input int i, input logic exp, input string name);
        #1;
        check(name, {31'h0, irq_o[i]}, {31'h0, exp});
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            addr[i] = 2'd0; cs[i] = 1'b0; wn[i] = 1'b1; wd[i] = 32'h0;
        end
        inp[0] = 8'h00; inp[1] = 8'hFF;
        cyc(3);
        rst_n = 1'b1;

        // Reset state
        rd_chk(0, 2'd0, 32'h00, "rst_data0");
        rd_chk(0, 2'd1, 32'h00, "rst_mask0");
        rd_chk(0, 2'd3, 32'h00, "rst_cap0");
        irq_chk(0, 1'b0, "rst_irq0");
        rd_chk(1, 2'd0, 32'hFF, "rst_data1");
        cyc(1);

        // Rising edges on bits 0 and 2
        inp[0] = 8'h05;
        cyc(10);
        rd_chk(0, 2'd0, 32'h05, "deb_latency");
        cyc(10);
        rd_chk(0, 2'd3, 32'h05, "cap_rise");
        irq_chk(0, 1'b0, "irq_masked");
        rd_chk(0, 2'd2, 32'h00, "reserved0");

        // Mask, then W1C
        wr(0, 2'd1, 32'h04);
        irq_chk(0, 1'b1, "irq_after_mask");
        wr(0, 2'd3, 32'h04);
        irq_chk(0, 1'b0, "irq_after_clr");
        rd_chk(0, 2'd3, 32'h01, "cap_after_clr4");
        wr(0, 2'd3, 32'h01);
        rd_chk(0, 2'd3, 32'h00, "cap_after_clr1");
        wr(0, 2'd0, 32'hFF);
        rd_chk(0, 2'd0, 32'h05, "data_ro");

        // Falling to zero (not captured on rising config), then glitches
        inp[0] = 8'h00;
        cyc(12);
        rd_chk(0, 2'd3, 32'h00, "fall_ignored");
        for (int p = 0; p < 4; p++) begin
            inp[0] = 8'h01;
            cyc(3);
            inp[0] = 8'h00;
            cyc(12 + p);
            rd_chk(0, 2'd0, 32'h00, $sformatf("glitch_data_p%0d", p));
            rd_chk(0, 2'd3, 32'h00, $sformatf("glitch_cap_p%0d", p));
        end

        // Reset mid-capture
        inp[0] = 8'h03;
        cyc(20);
        rd_chk(0, 2'd3, 32'h03, "cap03");
        wr(0, 2'd1, 32'h03);
        irq_chk(0, 1'b1, "irq_pre_reset");
        rst_n = 1'b0;
        irq_chk(0, 1'b0, "irq_in_reset");
        rd_chk(0, 2'd3, 32'h00, "cap_in_reset");
        rd_chk(0, 2'd1, 32'h00, "mask_in_reset");
        rd_chk(0, 2'd2, 32'h00, "reserved_in_reset");
        cyc(2);
        rst_n = 1'b1;
        inp[0] = 8'h00;

        // Falling-edge instance, idle-high inputs
        cyc(20);
        rd_chk(1, 2'd3, 32'h00, "f_idle");
        inp[1] = 8'hFE;
        cyc(20);
        rd_chk(1, 2'd3, 32'h01, "f_fall");
        inp[1] = 8'hFF;
        cyc(20);
        rd_chk(1, 2'd3, 32'h01, "f_rise_ignored");
        wr(1, 2'd3, 32'h01);
        rd_chk(1, 2'd3, 32'h00, "f_clr");

        // Edge and W1C of the same bit on the same edge
        while ((m_e % D) != 0) @(negedge clk);
        inp[1] = 8'hFE;
        cyc(8);
        wr(1, 2'd3, 32'h01);
        rd_chk(1, 2'd3, 32'h01, "set_wins");
        rd_chk(1, 2'd0, 32'hFE, "f_data");
        rd_chk(1, 2'd2, 32'h00, "reserved1");
        cyc(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
